// File: rtl/l4_datapath_if.sv
// rtl/l4_datapath_if.sv - control strobe and data bundle between controller and l4 datapath
interface l4_datapath_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2,
    parameter int IMM_W = 4
);
    logic [AW-1:0]    addr_x;
    logic [AW-1:0]    addr_y;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] ext_data;
    logic             _Extern;
    logic             Gout;
    logic             Iout;
    logic             RdX;
    logic             RdY;
    logic             Ain;
    logic             Gin;
    logic             add_sub;
    logic             WrX;
    logic             DPin;
    logic [WIDTH-1:0] bus_out;
    logic [WIDTH-1:0] g_out;
    logic [WIDTH-1:0] disp_out;
    logic             zero;
    logic             carry;
    logic             bus_err;

    modport master (
        output addr_x, addr_y, imm, ext_data,
        output _Extern, Gout, Iout, RdX, RdY, Ain, Gin, add_sub, WrX, DPin,
        input  bus_out, g_out, disp_out, zero, carry, bus_err
    );

    modport slave (
        input  addr_x, addr_y, imm, ext_data,
        input  _Extern, Gout, Iout, RdX, RdY, Ain, Gin, add_sub, WrX, DPin,
        output bus_out, g_out, disp_out, zero, carry, bus_err
    );
endinterface

// File: rtl/l4_datapath.sv
// rtl/l4_datapath.sv - single-bus datapath: register file, accumulator, ALU, G, flags, display
module l4_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = 2,
    parameter int IMM_W = 4
) (
    input logic         clk,
    input logic         reset,
    l4_datapath_if.slave dp
);
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] disp_q;
    logic             zero_q;
    logic             carry_q;
    logic             err_q;

    logic [WIDTH-1:0] bus;
    logic [WIDTH:0]   alu;
    logic [2:0]       n_drv;

    // Fixed-priority bus mux; an undriven bus reads as zero so MV computes A + 0.
    always_comb begin
        bus = '0;
        if (dp._Extern)   bus = dp.ext_data;
        else if (dp.Gout) bus = g_q;
        else if (dp.Iout) bus = {{(WIDTH-IMM_W){1'b0}}, dp.imm};
        else if (dp.RdX)  bus = regs[dp.addr_x];
        else if (dp.RdY)  bus = regs[dp.addr_y];
    end

    // Count asserted bus drivers to detect contention.
    always_comb begin
        n_drv = {2'b00, dp._Extern} + {2'b00, dp.Gout} + {2'b00, dp.Iout}
              + {2'b00, dp.RdX} + {2'b00, dp.RdY};
    end

    // One extra bit holds carry-out on add and borrow on subtract.
    always_comb begin
        if (dp.add_sub) alu = {1'b0, a_q} - {1'b0, bus};
        else            alu = {1'b0, a_q} + {1'b0, bus};
    end

    // Register file: combinational read above, synchronous write of X.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (dp.WrX) begin
            regs[dp.addr_x] <= bus;
        end
    end

    // Accumulator, result register, flags, display and sticky contention flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            g_q     <= '0;
            disp_q  <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (dp.Ain)  a_q    <= bus;
            if (dp.DPin) disp_q <= bus;
            if (dp.Gin) begin
                g_q     <= alu[WIDTH-1:0];
                zero_q  <= (alu[WIDTH-1:0] == '0);
                carry_q <= alu[WIDTH];
            end
            if (n_drv > 3'd1) err_q <= 1'b1;
        end
    end

    assign dp.bus_out  = bus;
    assign dp.g_out    = g_q;
    assign dp.disp_out = disp_q;
    assign dp.zero     = zero_q;
    assign dp.carry    = carry_q;
    assign dp.bus_err  = err_q;
endmodule

// File: tb/tb_l4_datapath.sv
// tb/tb_l4_datapath.sv - scoreboard bench for l4_datapath with a behavioural model
module tb_l4_datapath;
    typedef struct packed {
        logic       ext_s;
        logic       gout;
        logic       iout;
        logic       rdx;
        logic       rdy;
        logic       ain;
        logic       gin;
        logic       sub;
        logic       wrx;
        logic       dpin;
        logic [1:0] x;
        logic [1:0] y;
        logic [3:0] imm;
        logic [7:0] ext;
    } ctl_t;

    typedef struct packed {
        logic [7:0] bus;
        logic [7:0] g;
        logic [7:0] disp;
        logic       z;
        logic       c;
        logic       err;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];

    int m_r[4];
    int m_a, m_g, m_disp, m_z, m_c, m_err;

    l4_datapath_if #(.WIDTH(8), .AW(2), .IMM_W(4)) ifc ();
    l4_datapath #(.WIDTH(8), .NREGS(4), .AW(2), .IMM_W(4)) dut (
        .clk(clk), .reset(reset), .dp(ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input ctl_t c);
        ifc._Extern  = c.ext_s;
        ifc.Gout     = c.gout;
        ifc.Iout     = c.iout;
        ifc.RdX      = c.rdx;
        ifc.RdY      = c.rdy;
        ifc.Ain      = c.ain;
        ifc.Gin      = c.gin;
        ifc.add_sub  = c.sub;
        ifc.WrX      = c.wrx;
        ifc.DPin     = c.dpin;
        ifc.addr_x   = c.x;
        ifc.addr_y   = c.y;
        ifc.imm      = c.imm;
        ifc.ext_data = c.ext;
    endtask

    function automatic int model_bus(input ctl_t c);
        if (c.ext_s) return int'(c.ext);
        if (c.gout)  return m_g;
        if (c.iout)  return int'(c.imm);
        if (c.rdx)   return m_r[c.x];
        if (c.rdy)   return m_r[c.y];
        return 0;
    endfunction

    // One clock cycle: apply controls, record expected observation, advance model.
    task automatic step(input logic rst, input ctl_t c);
        obs_t e;
        int   b, r, n;
        drive(c);
        reset = rst;
        b = model_bus(c);
        e.bus = b[7:0]; e.g = m_g[7:0]; e.disp = m_disp[7:0];
        e.z = m_z[0]; e.c = m_c[0]; e.err = m_err[0];
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_a = 0; m_g = 0; m_disp = 0; m_z = 0; m_c = 0; m_err = 0;
        end else begin
            n = int'(c.ext_s) + int'(c.gout) + int'(c.iout) + int'(c.rdx) + int'(c.rdy);
            if (c.gin) begin
                r = c.sub ? (m_a - b) : (m_a + b);
                m_c = c.sub ? int'(m_a < b) : int'(r > 255);
                m_g = (r + 256) % 256;
                m_z = int'(m_g == 0);
            end
            if (c.ain)  m_a = b;
            if (c.wrx)  m_r[c.x] = b;
            if (c.dpin) m_disp = b;
            if (n > 1)  m_err = 1;
        end
        #1;
    endtask

    function automatic ctl_t idle();
        ctl_t c = '0;
        return c;
    endfunction

    task automatic load(input int idx, input int val);
        ctl_t c = idle();
        c.ext_s = 1; c.wrx = 1; c.x = 2'(idx); c.ext = 8'(val);
        step(1'b0, c);
    endtask

    // Combinational read of a register between edges; no state changes.
    task automatic peek(input string name, input int idx, input int exp);
        ctl_t c = idle();
        c.rdx = 1; c.x = 2'(idx);
        drive(c);
        #2;
        chk(name, int'(ifc.bus_out), exp);
        drive(idle());
        #1;
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            chk("bus_out", int'(ifc.bus_out), int'(e.bus));
            chk("g_out", int'(ifc.g_out), int'(e.g));
            chk("disp_out", int'(ifc.disp_out), int'(e.disp));
            chk("zero", int'(ifc.zero), int'(e.z));
            chk("carry", int'(ifc.carry), int'(e.c));
            chk("bus_err", int'(ifc.bus_err), int'(e.err));
        end
    end

    initial begin
        ctl_t c;
        drive(idle());
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        foreach (m_r[i]) m_r[i] = 0;
        m_a = 0; m_g = 0; m_disp = 0; m_z = 0; m_c = 0; m_err = 0;

        // Reset overrides a same-cycle write
        load(1, 8'h33);
        c = idle(); c.ext_s = 1; c.gin = 1; c.ext = 8'h44; step(1'b0, c);
        chk("preload_g", int'(ifc.g_out), 8'h44);
        c = idle(); c.wrx = 1; c.ext_s = 1; c.x = 1; c.ext = 8'hAA; step(1'b1, c);
        for (int i = 0; i < 4; i++) peek("reset_reg", i, 0);
        chk("reset_g", int'(ifc.g_out), 0);
        chk("reset_disp", int'(ifc.disp_out), 0);
        chk("reset_flags", int'({ifc.zero, ifc.carry, ifc.bus_err}), 0);

        // ADD
        load(1, 8'h05); load(2, 8'h03);
        c = idle(); c.ain = 1; c.rdy = 1; c.y = 2; step(1'b0, c);
        c = idle(); c.gin = 1; c.rdx = 1; c.x = 1; step(1'b0, c);
        c = idle(); c.gout = 1; c.wrx = 1; c.x = 1; step(1'b0, c);
        c = idle(); c.dpin = 1; c.rdx = 1; c.x = 1; step(1'b0, c);
        peek("add_r1", 1, 8'h08);
        chk("add_disp", int'(ifc.disp_out), 8'h08);
        chk("add_zc", int'({ifc.zero, ifc.carry}), 0);

        // SUB with borrow
        load(1, 8'h05);
        c = idle(); c.ain = 1; c.rdx = 1; c.x = 2; step(1'b0, c);
        c = idle(); c.gin = 1; c.sub = 1; c.rdy = 1; c.y = 1; step(1'b0, c);
        c = idle(); c.gout = 1; c.wrx = 1; c.x = 2; step(1'b0, c);
        peek("sub_r2", 2, 8'hFE);
        chk("sub_zc", int'({ifc.zero, ifc.carry}), 1);

        // ADDI wrapping to zero
        load(3, 8'hF1);
        c = idle(); c.ain = 1; c.rdx = 1; c.x = 3; step(1'b0, c);
        c = idle(); c.iout = 1; c.gin = 1; c.imm = 4'hF; step(1'b0, c);
        c = idle(); c.gout = 1; c.wrx = 1; c.x = 3; step(1'b0, c);
        peek("addi_r3", 3, 0);
        chk("addi_zc", int'({ifc.zero, ifc.carry}), 3);

        // MV through an undriven bus
        load(0, 8'h5A);
        c = idle(); c.ain = 1; c.rdy = 1; c.y = 0; step(1'b0, c);
        c = idle(); c.gin = 1; step(1'b0, c);
        c = idle(); c.gout = 1; c.wrx = 1; c.x = 1; step(1'b0, c);
        peek("mv_r1", 1, 8'h5A);
        chk("mv_zc", int'({ifc.zero, ifc.carry}), 0);

        // Bus contention: priority holds, error is sticky until reset
        c = idle(); c.ext_s = 1; c.ain = 1; c.ext = 8'h22; step(1'b0, c);
        c = idle(); c.gin = 1; step(1'b0, c);
        c = idle(); c.ext_s = 1; c.gout = 1; c.ext = 8'h11; c.wrx = 1; c.x = 0; step(1'b0, c);
        peek("conflict_r0", 0, 8'h11);
        chk("conflict_err", int'(ifc.bus_err), 1);
        repeat (5) step(1'b0, idle());
        chk("conflict_sticky", int'(ifc.bus_err), 1);
        step(1'b1, idle());
        chk("conflict_clear", int'(ifc.bus_err), 0);

        // Randomized control sequences against the model
        for (int k = 0; k < 400; k++) begin
            c = '0;
            c.ext_s = ($urandom_range(0, 5) == 0);
            c.gout  = ($urandom_range(0, 5) == 0);
            c.iout  = ($urandom_range(0, 5) == 0);
            c.rdx   = ($urandom_range(0, 3) == 0);
            c.rdy   = ($urandom_range(0, 3) == 0);
            c.ain   = ($urandom_range(0, 2) == 0);
            c.gin   = ($urandom_range(0, 2) == 0);
            c.sub   = $urandom_range(0, 1) == 1;
            c.wrx   = ($urandom_range(0, 2) == 0);
            c.dpin  = ($urandom_range(0, 3) == 0);
            c.x     = 2'($urandom_range(0, 3));
            c.y     = 2'($urandom_range(0, 3));
            c.imm   = 4'($urandom_range(0, 15));
            c.ext   = 8'($urandom_range(0, 255));
            step($urandom_range(0, 40) == 0, c);
        end

        drive(idle());
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l4_datapath.md
Name: l4_datapath

Overview:
- Datapath for the lab 4 single-bus processor, directly downstream of the control state machine.
- Consumes the per-state control strobes (_Extern, Gout, Iout, Ain, Gin, DPin, RdX, RdY, WrX, add_sub) each cycle.
- Contains a register file, A accumulator, ALU, G result register, status flags and display register.
- Executes LOAD, MV, ADD, SUB, ADDI, SUBI and DISP over the multi-cycle sequences the FSM issues.

Parameters:
- WIDTH, 8, data and bus width in bits.
- NREGS, 4, register file depth (power of 2).
- AW, 2, register address width (log2 NREGS).
- IMM_W, 4, immediate field width; zero-extended to WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr_x  input  AW  register index X, from the instruction latch.
- addr_y  input  AW  register index Y, from the instruction latch.
- imm  input  IMM_W  immediate field, from the instruction latch.
- ext_data  input  WIDTH  external data for LOAD.
- _Extern  input  1  drive ext_data onto bus.
- Gout  input  1  drive G onto bus.
- Iout  input  1  drive zero-extended imm onto bus.
- RdX  input  1  drive R[addr_x] onto bus.
- RdY  input  1  drive R[addr_y] onto bus.
- Ain  input  1  A <= bus.
- Gin  input  1  G <= ALU result; update flags.
- add_sub  input  1  0 = A+bus, 1 = A-bus.
- WrX  input  1  R[addr_x] <= bus.
- DPin  input  1  disp <= bus.
- bus_out  output  WIDTH  current bus value (combinational, debug).
- g_out  output  WIDTH  G register.
- disp_out  output  WIDTH  display register.
- zero  output  1  registered zero flag.
- carry  output  1  registered carry/borrow flag.
- bus_err  output  1  sticky multi-driver error.

Behaviour:
- Reset (reset=1 at a rising edge):
  - All R[i], A, G, disp_out, zero, carry and bus_err become 0.
  - Reset overrides every strobe asserted in the same cycle; no write occurs.
- Bus selection (combinational, fixed priority): _Extern > Gout > Iout > RdX > RdY.
  - Selected sources: ext_data, G, {0, imm}, R[addr_x], R[addr_y].
  - With no driver asserted, bus = 0. MV relies on this: G <= A + 0.
- Register file reads are combinational; all writes are synchronous.
- A same-cycle read and write of the same register returns the old value.
- Ain: A <= bus at the next edge.
- WrX: R[addr_x] <= bus at the next edge.
- DPin: disp_out <= bus at the next edge.
- Gin: G <= result at the next edge, where result = (A ± bus) mod 2^WIDTH.
  - ALU uses the A value from before any same-cycle Ain.
- Flags update only on Gin:
  - zero <= (result == 0).
  - carry <= carry-out of the add when add_sub=0; borrow (A < bus, unsigned) when add_sub=1.
  - Flags hold otherwise.
- bus_err: set to 1 at an edge where two or more bus drivers are asserted. Stays 1 until reset. The bus still follows the priority rule.
- Latency:
  - LOAD: 1 cycle.
  - ADD, SUB, ADDI, SUBI, MV: 3 cycles (read into A, ALU into G, write to X).
  - DISP: 1 cycle.
  - A written value is visible on a RdX/RdY read in the following cycle.
- Idle (all strobes 0): all state holds.
- Simultaneous Ain+Gin, or Gin+WrX: each target samples its own pre-edge inputs. No forwarding is performed.

Test Plan:
- Reset: preload R1=0x33 and G=0x44, then pulse reset with WrX=1 and ext_data=0xAA. Required: all registers, flags, disp_out and bus_err read 0; no write occurs.
- ADD sequence:
  - LOAD R1=0x05, then LOAD R2=0x03.
  - READ_Y (Ain,RdY; y=2), ADD (Gin,RdX; x=1), WRITE_X (Gout,WrX; x=1), DISP (DPin,RdX).
  - Required: R1=0x08, disp_out=0x08, zero=0, carry=0.
- SUB sequence: with R2=0x03 and R1=0x05, x=2, y=1: READ_X, SUB (add_sub=1, RdY), WRITE_X. Required: R2=0xFE, carry=1, zero=0.
- ADDI sequence: R3=0xF1, imm=0xF, x=3: READ_X, ADDI (Iout,Gin), WRITE_X. Required: R3=0x00, zero=1, carry=1.
- MV sequence: R0=0x5A, x=1, y=0: READ_Y, MV (Gin only), WRITE_X. Required: R1=0x5A, flags zero=0 and carry=0.
- Bus conflict: assert _Extern and Gout together with ext_data=0x11, G=0x22, WrX=1, x=0. Required: R0=0x11, bus_err=1 and still 1 after 5 idle cycles, cleared only by reset.
